barrier_scroller: RTL and testbench

Moves the on-screen barrier and consumes the game's barrier speed. Each frame tick it advances the barrier's right-edge X coordinate left by the current speed. When the barrier leaves the screen, the block respawns it at the right edge, counts it as passed, and raises the speed one step every `LEVEL_STEP` barriers. It sits between the frame-tick generator and the VGA renderer and collision checker. It owns the `barrier_speed` register: the speed is loaded to `SPEED_RESET` on game start and ramped from there.

---
 rtl/barrier_scroller.sv | 103 ++++++++++
 tb/tb_barrier_scroller.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/barrier_scroller.sv
// barrier_scroller: scrolls the barrier left once per frame, respawns it at the right edge,
// counts passed barriers and ramps the barrier speed every LEVEL_STEP barriers.
module barrier_scroller #(
    parameter int SCREEN_W    = 640,
    parameter int BARRIER_W   = 32,
    parameter int X_W         = 10,
    parameter int SPEED_W     = 4,
    parameter int SPEED_RESET = 4,
    parameter int SPEED_MAX   = 12,
    parameter int LEVEL_STEP  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               start,
    input  logic               pause,
    input  logic               crash,
    output logic [X_W-1:0]     barrier_x,
    output logic [SPEED_W-1:0] barrier_speed,
    output logic [15:0]        passed_cnt,
    output logic               respawn,
    output logic               running,
    output logic               game_over
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSED, OVER} state_t;

    localparam logic [X_W-1:0]     X_START = X_W'(SCREEN_W + BARRIER_W);
    localparam logic [SPEED_W-1:0] SPD_RST = SPEED_W'(SPEED_RESET);
    localparam logic [SPEED_W-1:0] SPD_MAX = SPEED_W'(SPEED_MAX);
    localparam logic [15:0]        LVL_MSK = 16'(LEVEL_STEP - 1);

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [SPEED_W-1:0] speed_q, speed_d;
    logic [15:0]        cnt_q, cnt_d;
    logic               respawn_q, respawn_d;

    logic [15:0] cnt_inc;
    logic        hit;
    logic        init;

    assign cnt_inc = cnt_q + 16'd1;
    // Speed is zero-extended so the compare stays unsigned at the X width.
    assign hit = x_q <= X_W'(speed_q);
    assign init = start && (state_q != RUN);

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        speed_d   = speed_q;
        cnt_d     = cnt_q;
        respawn_d = 1'b0;
        case (state_q)
            IDLE:   state_d = start ? RUN : IDLE;
            PAUSED: state_d = (start || pause) ? RUN : PAUSED;
            OVER:   state_d = start ? RUN : OVER;
            RUN: begin
                if (crash) begin
                    state_d = OVER;
                end else if (pause) begin
                    state_d = PAUSED;
                end else if (frame_tick && hit) begin
                    x_d       = X_START;
                    cnt_d     = cnt_inc;
                    respawn_d = 1'b1;
                    if ((cnt_inc & LVL_MSK) == 16'd0)
                        speed_d = (speed_q >= SPD_MAX) ? SPD_MAX : speed_q + 1'b1;
                end else if (frame_tick) begin
                    x_d = x_q - X_W'(speed_q);
                end
            end
            default: state_d = IDLE;
        endcase
        if (init) begin
            x_d     = X_START;
            speed_d = SPD_RST;
            cnt_d   = 16'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            x_q       <= X_START;
            speed_q   <= SPD_RST;
            cnt_q     <= 16'd0;
            respawn_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            speed_q   <= speed_d;
            cnt_q     <= cnt_d;
            respawn_q <= respawn_d;
        end
    end

    assign barrier_x     = x_q;
    assign barrier_speed = speed_q;
    assign passed_cnt    = cnt_q;
    assign respawn       = respawn_q;
    assign running       = state_q == RUN;
    assign game_over     = state_q == OVER;
endmodule

// File: tb/tb_barrier_scroller.sv
// tb_barrier_scroller: directed scenario tasks for barrier_scroller at default parameters.
module tb_barrier_scroller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic        crash = 1'b0;
    logic [9:0]  barrier_x;
    logic [3:0]  barrier_speed;
    logic [15:0] passed_cnt;
    logic        respawn;
    logic        running;
    logic        game_over;

    int compared = 0;
    int mismatched = 0;
    int resp_seen = 0;

    barrier_scroller dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
        .crash(crash), .barrier_x(barrier_x), .barrier_speed(barrier_speed),
        .passed_cnt(passed_cnt), .respawn(respawn), .running(running), .game_over(game_over)
    );

    always #5 clk = ~clk;
    always @(negedge clk) if (respawn) resp_seen++;

    task automatic drive(input logic t, input logic s, input logic p, input logic c, input int n);
        @(negedge clk);
        frame_tick = t; start = s; pause = p; crash = c;
        repeat (n) @(negedge clk);
        frame_tick = 0; start = 0; pause = 0; crash = 0;
    endtask

    task automatic run_until(input int target, input string name);
        int n = 0;
        @(negedge clk);
        frame_tick = 1;
        while (passed_cnt != 16'(target) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        frame_tick = 0;
        compared++;
        if (passed_cnt !== 16'(target)) begin
            mismatched++;
            $display("FAIL %s timeout: passed_cnt=%0d want %0d", name, passed_cnt, target);
        end
    endtask

    task automatic test_reset;
        rst = 1;
        #12;
        rst = 0;
        compared++; if (barrier_x !== 10'd672) begin mismatched++; $display("FAIL reset_x: got %0d want 672", barrier_x); end
        compared++; if (barrier_speed !== 4'd4) begin mismatched++; $display("FAIL reset_speed: got %0d want 4", barrier_speed); end
        compared++; if (passed_cnt !== 16'd0) begin mismatched++; $display("FAIL reset_cnt: got %0d want 0", passed_cnt); end
        compared++; if ({respawn, running, game_over} !== 3'b000) begin mismatched++; $display("FAIL reset_flags: got %b want 000", {respawn, running, game_over}); end
        drive(1, 0, 0, 0, 5);
        compared++; if (barrier_x !== 10'd672 || running !== 1'b0) begin mismatched++; $display("FAIL idle_tick: got x=%0d run=%b want 672/0", barrier_x, running); end
    endtask

    task automatic test_scroll;
        int base;
        drive(0, 1, 0, 0, 1);
        compared++; if (running !== 1'b1 || barrier_x !== 10'd672) begin mismatched++; $display("FAIL start: got run=%b x=%0d want 1/672", running, barrier_x); end
        base = resp_seen;
        drive(1, 0, 0, 0, 167);
        compared++; if (barrier_x !== 10'd4) begin mismatched++; $display("FAIL tick167_x: got %0d want 4", barrier_x); end
        compared++; if (resp_seen !== base) begin mismatched++; $display("FAIL early_respawn: got %0d want %0d", resp_seen, base); end
        drive(1, 0, 0, 0, 1);
        compared++; if (barrier_x !== 10'd672 || passed_cnt !== 16'd1) begin mismatched++; $display("FAIL tick168: got x=%0d cnt=%0d want 672/1", barrier_x, passed_cnt); end
        compared++; if (respawn !== 1'b1) begin mismatched++; $display("FAIL respawn_pulse: got %b want 1", respawn); end
        @(negedge clk);
        compared++; if (respawn !== 1'b0 || resp_seen !== base + 1) begin mismatched++; $display("FAIL respawn_width: got %b seen=%0d want 0/%0d", respawn, resp_seen, base + 1); end
    endtask

    task automatic test_speedup;
        drive(1, 0, 0, 0, 1176);
        compared++; if (passed_cnt !== 16'd8 || barrier_speed !== 4'd5) begin mismatched++; $display("FAIL level1: got cnt=%0d spd=%0d want 8/5", passed_cnt, barrier_speed); end
        run_until(64, "to64");
        compared++; if (barrier_speed !== 4'd12) begin mismatched++; $display("FAIL speed64: got %0d want 12", barrier_speed); end
        run_until(72, "to72");
        compared++; if (barrier_speed !== 4'd12 || barrier_x !== 10'd672) begin mismatched++; $display("FAIL speed72: got spd=%0d x=%0d want 12/672", barrier_speed, barrier_x); end
    endtask

    task automatic test_crash;
        drive(1, 0, 0, 0, 3);
        compared++; if (barrier_x !== 10'd636) begin mismatched++; $display("FAIL pre_crash_x: got %0d want 636", barrier_x); end
        drive(1, 0, 0, 1, 1);
        compared++; if (barrier_x !== 10'd636 || game_over !== 1'b1 || running !== 1'b0) begin mismatched++; $display("FAIL crash: got x=%0d go=%b run=%b want 636/1/0", barrier_x, game_over, running); end
        drive(1, 0, 1, 0, 2);
        compared++; if (barrier_x !== 10'd636 || game_over !== 1'b1) begin mismatched++; $display("FAIL over_frozen: got x=%0d go=%b want 636/1", barrier_x, game_over); end
        drive(1, 1, 0, 0, 1);
        compared++; if ({barrier_x, barrier_speed, passed_cnt} !== {10'd672, 4'd4, 16'd0} || running !== 1'b1 || game_over !== 1'b0) begin
            mismatched++; $display("FAIL restart: got x=%0d spd=%0d cnt=%0d run=%b go=%b want 672/4/0/1/0", barrier_x, barrier_speed, passed_cnt, running, game_over);
        end
    endtask

    task automatic test_pause;
        drive(1, 0, 0, 0, 2);
        drive(1, 0, 1, 0, 1);
        compared++; if (barrier_x !== 10'd664 || running !== 1'b0) begin mismatched++; $display("FAIL pause_enter: got x=%0d run=%b want 664/0", barrier_x, running); end
        drive(1, 0, 0, 0, 10);
        drive(0, 0, 0, 1, 1);
        compared++; if (barrier_x !== 10'd664 || running !== 1'b0 || game_over !== 1'b0) begin mismatched++; $display("FAIL paused_frozen: got x=%0d run=%b go=%b want 664/0/0", barrier_x, running, game_over); end
        drive(0, 0, 1, 0, 1);
        compared++; if (running !== 1'b1) begin mismatched++; $display("FAIL resume: got %b want 1", running); end
        drive(1, 0, 0, 0, 1);
        compared++; if (barrier_x !== 10'd660) begin mismatched++; $display("FAIL resume_tick: got %0d want 660", barrier_x); end
        drive(0, 1, 0, 0, 1);
        compared++; if (barrier_x !== 10'd660 || running !== 1'b1) begin mismatched++; $display("FAIL start_in_run: got x=%0d run=%b want 660/1", barrier_x, running); end
    endtask

    task automatic test_async_reset;
        run_until(16, "to16");
        drive(1, 0, 0, 0, 62);
        compared++; if (barrier_x !== 10'd300 || barrier_speed !== 4'd6) begin mismatched++; $display("FAIL pre_reset: got x=%0d spd=%0d want 300/6", barrier_x, barrier_speed); end
        @(negedge clk);
        #1 rst = 1;
        #1;
        compared++; if ({barrier_x, barrier_speed, passed_cnt} !== {10'd672, 4'd4, 16'd0} || running !== 1'b0) begin
            mismatched++; $display("FAIL async_reset: got x=%0d spd=%0d cnt=%0d run=%b want 672/4/0/0", barrier_x, barrier_speed, passed_cnt, running);
        end
        @(negedge clk);
        rst = 0;
        drive(1, 0, 0, 0, 5);
        compared++; if (barrier_x !== 10'd672 || running !== 1'b0) begin mismatched++; $display("FAIL post_reset_idle: got x=%0d run=%b want 672/0", barrier_x, running); end
    endtask

    task automatic test_wrap;
        drive(0, 1, 0, 0, 1);
        drive(0, 0, 1, 0, 1);
        @(negedge clk);
        force dut.cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.cnt_q;
        @(negedge clk);
        compared++; if (passed_cnt !== 16'hFFFF) begin mismatched++; $display("FAIL preload: got %0d want 65535", passed_cnt); end
        drive(0, 0, 1, 0, 1);
        drive(1, 0, 0, 0, 168);
        compared++; if (passed_cnt !== 16'd0 || barrier_speed !== 4'd5 || barrier_x !== 10'd672) begin
            mismatched++; $display("FAIL wrap: got cnt=%0d spd=%0d x=%0d want 0/5/672", passed_cnt, barrier_speed, barrier_x);
        end
    endtask

    initial begin
        test_reset;
        test_scroll;
        test_speedup;
        test_crash;
        test_pause;
        test_async_reset;
        test_wrap;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
